// File: rtl/noise_pkg.sv
// Shared constants and frame header layout for the multi-channel noise generator.
package noise_pkg;

  localparam int unsigned CH_IDX_W = 5;
  localparam int unsigned HDR_W    = 8;

  // Header bit positions within the top byte of a frame
  localparam int unsigned HDR_LOAD_BIT = 7;
  localparam int unsigned HDR_MODE_BIT = 6;
  localparam int unsigned HDR_EN_BIT   = 5;

  localparam logic MODE_LONG  = 1'b0;
  localparam logic MODE_SHORT = 1'b1;

  typedef struct packed {
    logic                load;
    logic                mode;
    logic                en;
    logic [CH_IDX_W-1:0] ch;
  } frame_hdr_t;

endpackage

// File: rtl/noise_lfsr_ch.sv
// One noise voice: divider counter, long/short LFSR, enable and registered output bit.
module noise_lfsr_ch
  import noise_pkg::*;
#(
  parameter int unsigned      LFSR_W      = 23,
  parameter int unsigned      TAP_LONG    = 17,
  parameter int unsigned      SHORT_W     = 7,
  parameter int unsigned      DIV_W       = 17,
  parameter logic [LFSR_W-1:0] SEED       = 23'd111,
  parameter logic [DIV_W-1:0]  DEFAULT_DIV = 17'd13000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              commit_i,
  input  logic              load_i,
  input  logic              mode_i,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [LFSR_W-1:0] lfsr_i,
  output logic              noise_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              en_q, en_d;
  logic              out_q, out_d;

  // True when the field used by mode m is all zero (lock-up state)
  function automatic logic act_zero(input logic [LFSR_W-1:0] v, input logic m);
    if (m == MODE_SHORT) begin
      return v[SHORT_W-1:0] == '0;
    end
    return v == '0;
  endfunction

  always_comb begin
    lfsr_d = lfsr_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    en_d   = en_q;
    out_d  = out_q;
    if (commit_i) begin
      // A commit overrides any tick due this cycle
      div_d  = div_i;
      mode_d = mode_i;
      en_d   = en_i;
      cnt_d  = '0;
      if (load_i) begin
        lfsr_d = act_zero(lfsr_i, mode_i) ? SEED : lfsr_i;
      end
    end else if (!en_q) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (cnt_q == div_q) begin
      cnt_d = '0;
      if (act_zero(lfsr_q, mode_q)) begin
        lfsr_d = SEED;
        out_d  = 1'b0;
      end else if (mode_q == MODE_SHORT) begin
        lfsr_d[SHORT_W-1:0] = {lfsr_q[SHORT_W-2:0], lfsr_q[SHORT_W-1] ^ lfsr_q[SHORT_W-2]};
        out_d               = lfsr_q[SHORT_W-1];
      end else begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[TAP_LONG]};
        out_d  = lfsr_q[LFSR_W-1];
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
      div_q  <= DEFAULT_DIV;
      cnt_q  <= '0;
      mode_q <= MODE_LONG;
      en_q   <= 1'b1;
      out_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      en_q   <= en_d;
      out_q  <= out_d;
    end
  end

  assign noise_o = out_q;

endmodule

// File: rtl/noise_gen_mc.sv
// Multi-channel LFSR noise generator programmed by channel-addressed SPI frames.
module noise_gen_mc
  import noise_pkg::*;
#(
  parameter int unsigned       NUM_CH      = 4,
  parameter int unsigned       LFSR_W      = 23,
  parameter int unsigned       TAP_LONG    = 17,
  parameter int unsigned       SHORT_W     = 7,
  parameter int unsigned       DIV_W       = 17,
  parameter logic [LFSR_W-1:0] SEED        = 23'd111,
  parameter logic [DIV_W-1:0]  DEFAULT_DIV = 17'd13000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              spi_clock,
  input  logic              spi_data,
  input  logic              spi_cs,
  output logic [NUM_CH-1:0] noise_out,
  output logic              frame_ok,
  output logic              frame_err
);

  localparam int unsigned FRAME_W = HDR_W + DIV_W + LFSR_W;
  localparam int unsigned BCNT_W  = $clog2(FRAME_W + 2);
  localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(FRAME_W);
  localparam logic [BCNT_W-1:0] BCNT_SAT  = BCNT_W'(FRAME_W + 1);

  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  // Idle values on reset so no spurious edge is seen when reset releases
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sck_q  <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_clock};
      cs_q   <= {cs_q[1:0], spi_cs};
      mosi_q <= {mosi_q[0], spi_data};
    end
  end

  logic sck_rise, cs_fall, cs_rise, cs_active;

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_active = ~cs_q[1];

  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic               armed_q, armed_d;
  logic               commit_q, commit_d;
  logic               err_q, err_d;

  // armed_q marks a frame whose start was seen since the last reset
  always_comb begin
    shreg_d  = shreg_q;
    bcnt_d   = bcnt_q;
    armed_d  = armed_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    if (cs_fall) begin
      bcnt_d  = '0;
      armed_d = 1'b1;
    end else if (armed_q && cs_active && sck_rise) begin
      shreg_d = {shreg_q[FRAME_W-2:0], mosi_q[1]};
      if (bcnt_q != BCNT_SAT) begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end
    if (armed_q && cs_rise) begin
      armed_d  = 1'b0;
      commit_d = (bcnt_q == BCNT_FULL);
      err_d    = (bcnt_q != BCNT_FULL);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shreg_q  <= '0;
      bcnt_q   <= '0;
      armed_q  <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      bcnt_q   <= bcnt_d;
      armed_q  <= armed_d;
      commit_q <= commit_d;
      err_q    <= err_d;
    end
  end

  assign frame_ok  = commit_q;
  assign frame_err = err_q;

  frame_hdr_t         hdr;
  logic [DIV_W-1:0]   cfg_div;
  logic [LFSR_W-1:0]  cfg_lfsr;
  logic [NUM_CH-1:0]  ch_commit;

  assign hdr      = shreg_q[FRAME_W-1 -: HDR_W];
  assign cfg_div  = shreg_q[LFSR_W +: DIV_W];
  assign cfg_lfsr = shreg_q[LFSR_W-1:0];

  // Indices at or above NUM_CH match no channel
  always_comb begin
    ch_commit = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ch_commit[c] = commit_q && (hdr.ch == CH_IDX_W'(c));
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    noise_lfsr_ch #(
      .LFSR_W      (LFSR_W),
      .TAP_LONG    (TAP_LONG),
      .SHORT_W     (SHORT_W),
      .DIV_W       (DIV_W),
      .SEED        (SEED),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i    (sys_clk),
      .rst_i    (sys_rst),
      .commit_i (ch_commit[c]),
      .load_i   (hdr.load),
      .mode_i   (hdr.mode),
      .en_i     (hdr.en),
      .div_i    (cfg_div),
      .lfsr_i   (cfg_lfsr),
      .noise_o  (noise_out[c])
    );
  end

endmodule

// File: tb/tb_noise_gen_mc.sv
// Directed bench for noise_gen_mc: SPI frames, tick timing, modes, errors and reset abort.
module tb_noise_gen_mc;

  localparam int unsigned NUM_CH = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              spi_clock;
  logic              spi_data;
  logic              spi_cs;
  logic [NUM_CH-1:0] noise_out;
  logic              frame_ok;
  logic              frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int ok_cnt   = 0;
  int err_cnt  = 0;

  noise_gen_mc dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .spi_clock (spi_clock),
    .spi_data  (spi_data),
    .spi_cs    (spi_cs),
    .noise_out (noise_out),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (frame_ok)  ok_cnt  <= ok_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mk(input logic ld, input logic md, input logic en,
                                     input logic [4:0] ch, input logic [16:0] dv,
                                     input logic [22:0] lf);
    return {ld, md, en, ch, dv, lf};
  endfunction

  // Sends nbits MSB-first; pulses sys_rst before bit rst_at when rst_at >= 0
  task automatic send_frame(input logic [47:0] f, input int nbits, input int rst_at);
    @(negedge sys_clk);
    spi_cs = 1'b0;
    repeat (4) @(negedge sys_clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
      end
      spi_data = (i < 48) ? f[47-i] : 1'b0;
      repeat (4) @(negedge sys_clk);
      spi_clock = 1'b1;
      repeat (4) @(negedge sys_clk);
      spi_clock = 1'b0;
    end
    repeat (4) @(negedge sys_clk);
    spi_cs = 1'b1;
  endtask

  // Returns at the negedge where frame_ok is high; the next posedge applies the commit
  task automatic wait_ok(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge sys_clk);
      if (frame_ok) seen = 1'b1;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  // ch1 long, div=3, lfsr=1: zero for 22 ticks, one on tick 23 (92 cycles after commit)
  task automatic check_ch1_timing(input string tag);
    int ones = 0;
    int others = 0;
    logic last;
    for (int i = 1; i <= 93; i++) begin
      @(negedge sys_clk);
      if (i <= 92) ones += int'(noise_out[1]);
      else last = noise_out[1];
      others += int'(noise_out[0]) + int'(noise_out[2]) + int'(noise_out[3]);
    end
    check_eq({tag, "_zero22"}, 32'(ones), 32'd0);
    check_eq({tag, "_tick23"}, 32'(last), 32'd1);
    check_eq({tag, "_others"}, 32'(others), 32'd0);
  endtask

  task automatic count_ones(input int idx, input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      ones += int'(noise_out[idx]);
    end
  endtask

  initial begin
    logic [23:0] seq;
    logic        s[254];
    int          ones;
    int          mism;
    int          ok0;
    int          err0;

    sys_rst   = 1'b1;
    spi_clock = 1'b0;
    spi_data  = 1'b0;
    spi_cs    = 1'b1;
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    check_eq("rst_noise", 32'(noise_out), 32'd0);
    check_eq("rst_ok", 32'(frame_ok), 32'd0);
    check_eq("rst_err", 32'(frame_err), 32'd0);

    send_frame(mk(1'b1, 1'b0, 1'b1, 5'd1, 17'd3, 23'd1), 48, -1);
    wait_ok("ok_ch1");
    check_ch1_timing("ch1");

    // Short mode from 7'h01: six zeros then a one, then period 127 with 64 ones
    send_frame(mk(1'b1, 1'b1, 1'b1, 5'd2, 17'd0, 23'd1), 48, -1);
    wait_ok("ok_ch2");
    seq = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge sys_clk);
      if (i >= 2) seq = {seq[22:0], noise_out[2]};
    end
    check_eq("ch2_start", 32'(seq), 32'h01);
    for (int i = 0; i < 254; i++) begin
      @(negedge sys_clk);
      s[i] = noise_out[2];
    end
    mism = 0;
    ones = 0;
    for (int i = 0; i < 127; i++) begin
      if (s[i] != s[i+127]) mism++;
      ones += int'(s[i]);
    end
    check_eq("ch2_period", 32'(mism), 32'd0);
    check_eq("ch2_ones", 32'(ones), 32'd64);

    // Short and long frames are discarded; ch2 keeps running
    ok0  = ok_cnt;
    err0 = err_cnt;
    send_frame(mk(1'b1, 1'b0, 1'b0, 5'd2, 17'd5, 23'd0), 47, -1);
    repeat (20) @(negedge sys_clk);
    check_eq("err47", 32'(err_cnt - err0), 32'd1);
    send_frame(mk(1'b1, 1'b0, 1'b0, 5'd2, 17'd5, 23'd0), 49, -1);
    repeat (20) @(negedge sys_clk);
    check_eq("err49", 32'(err_cnt - err0), 32'd2);
    check_eq("err_no_ok", 32'(ok_cnt - ok0), 32'd0);
    count_ones(2, 127, ones);
    check_eq("ch2_after_err", 32'(ones), 32'd64);

    // Channel 6 does not exist; ch2 (same low index bits) must be untouched
    send_frame(mk(1'b1, 1'b0, 1'b0, 5'd6, 17'd5, 23'd0), 48, -1);
    wait_ok("ok_ch6");
    repeat (10) @(negedge sys_clk);
    count_ones(2, 127, ones);
    check_eq("ch6_ignored", 32'(ones), 32'd64);

    // Zero load becomes SEED: ticks 1..23 emit SEED bits 22..0
    send_frame(mk(1'b1, 1'b0, 1'b1, 5'd0, 17'd0, 23'd0), 48, -1);
    wait_ok("ok_ch0");
    seq = '0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge sys_clk);
      if (i >= 2) seq = {seq[22:0], noise_out[0]};
    end
    check_eq("ch0_seed", 32'(seq), 32'd111);

    // ch3: all-ones, slow divider, so output is 1 when the disable lands
    send_frame(mk(1'b1, 1'b0, 1'b1, 5'd3, 17'd1000, 23'h7fffff), 48, -1);
    wait_ok("ok_ch3_run");
    repeat (1010) @(negedge sys_clk);
    check_eq("ch3_high", 32'(noise_out[3]), 32'd1);
    send_frame(mk(1'b1, 1'b0, 1'b0, 5'd3, 17'd0, 23'h400000), 48, -1);
    wait_ok("ok_ch3_dis");
    @(negedge sys_clk);
    check_eq("ch3_commit_hold", 32'(noise_out[3]), 32'd1);
    @(negedge sys_clk);
    check_eq("ch3_dis_zero", 32'(noise_out[3]), 32'd0);
    count_ones(3, 200, ones);
    check_eq("ch3_dis_quiet", 32'(ones), 32'd0);
    // Re-enable without load: held 0x400000 gives 1, 22 zeros, then 1
    send_frame(mk(1'b0, 1'b0, 1'b1, 5'd3, 17'd0, 23'h0), 48, -1);
    wait_ok("ok_ch3_en");
    seq = '0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge sys_clk);
      if (i >= 2) seq = {seq[22:0], noise_out[3]};
    end
    check_eq("ch3_resume", 32'(seq), 32'h800001);

    // Reset mid-frame: no commit, channels back to reset state
    ok0 = ok_cnt;
    send_frame(mk(1'b1, 1'b0, 1'b1, 5'd1, 17'd3, 23'd1), 48, 20);
    repeat (30) @(negedge sys_clk);
    check_eq("rst_abort_no_ok", 32'(ok_cnt - ok0), 32'd0);
    ones = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      ones += int'(noise_out != '0);
    end
    check_eq("rst_abort_quiet", 32'(ones), 32'd0);
    send_frame(mk(1'b1, 1'b0, 1'b1, 5'd1, 17'd3, 23'd1), 48, -1);
    wait_ok("ok_after_rst");
    check_ch1_timing("ch1_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
